// File: rtl/adder_check_monitor.sv
// adder_check_monitor: compares a DUV adder against a reference adder one
// vector per cycle, counts checked/failing vectors, captures the first
// failing vector and gives a pass/fail verdict after file_size vectors.
// The compare-mode parameter is named cmp_type because "type" is a reserved
// word in SystemVerilog.
module adder_check_monitor #(
  parameter int n         = 32,
  parameter bit cmp_type  = 1'b1,
  parameter int file_size = 30000,
  parameter int CW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          valid,
  input  logic          cin,
  input  logic [n-1:0]  a,
  input  logic [n-1:0]  b,
  input  logic [n-1:0]  s_ref,
  input  logic [n-1:0]  s_duv,
  input  logic          cout_ref,
  input  logic          cout_duv,
  input  logic          prop_ref,
  input  logic          gen_ref,
  input  logic          prop_duv,
  input  logic          gen_duv,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          mismatch,
  output logic [CW-1:0] vec_count,
  output logic [CW-1:0] err_count,
  output logic [2:0]    err_flags,
  output logic          ff_valid,
  output logic [CW-1:0] ff_idx,
  output logic [n-1:0]  ff_a,
  output logic [n-1:0]  ff_b,
  output logic          ff_cin
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic          start_acc;  // start honoured only outside RUN
  logic          chk;        // a vector is checked at this edge
  logic          m_sum, m_cout, m_pg, mm;
  logic [CW-1:0] vec_nxt, err_nxt;
  logic          last;       // this edge checks the final vector of the run

  assign start_acc = start && (state != RUN);
  assign chk       = valid && (state == RUN);
  assign m_sum     = (s_ref != s_duv);
  assign m_cout    = (cout_ref != cout_duv);
  assign m_pg      = cmp_type && ((prop_ref != prop_duv) || (gen_ref != gen_duv));
  assign mm        = chk && (m_sum || m_cout || m_pg);
  assign vec_nxt   = vec_count + 1'b1;
  assign err_nxt   = (mm && (err_count != '1)) ? err_count + 1'b1 : err_count;
  assign last      = chk && (vec_nxt == CW'(file_size));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a start in RUN is ignored, so only the final vector leaves RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Counters, sticky flags, verdict and per-vector mismatch flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count <= '0;
      err_count <= '0;
      err_flags <= '0;
      mismatch  <= 1'b0;
      pass      <= 1'b0;
    end else if (start_acc) begin
      vec_count <= '0;
      err_count <= '0;
      err_flags <= '0;
      mismatch  <= 1'b0;
      pass      <= 1'b0;
    end else begin
      mismatch <= mm;
      if (chk) begin
        vec_count <= vec_nxt;
        err_count <= err_nxt;
        if (mm) err_flags <= err_flags | {m_pg, m_cout, m_sum};
      end
      if (last) pass <= (err_nxt == '0);
    end
  end

  // First-fail capture; later failures never overwrite it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
      ff_a     <= '0;
      ff_b     <= '0;
      ff_cin   <= 1'b0;
    end else if (start_acc) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
      ff_a     <= '0;
      ff_b     <= '0;
      ff_cin   <= 1'b0;
    end else if (mm && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_idx   <= vec_count;
      ff_a     <= a;
      ff_b     <= b;
      ff_cin   <= cin;
    end
  end

endmodule

// File: tb/tb_adder_check_monitor.sv
// Directed bench for adder_check_monitor: three instances share stimulus
// (compare mode 1 and 0 with four-vector runs, and a 2-bit-counter
// three-vector run) and are checked against hand-computed values.
module tb_adder_check_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, valid = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, s_ref = '0, s_duv = '0;
  logic       cout_ref = 1'b0, cout_duv = 1'b0;
  logic       prop_ref = 1'b0, gen_ref = 1'b0, prop_duv = 1'b0, gen_duv = 1'b0;

  // instance with prop/gen compare
  logic        busy1, done1, pass1, mm1, ffv1, ffcin1;
  logic [31:0] vec1, err1, ffidx1;
  logic [2:0]  fl1;
  logic [7:0]  ffa1, ffb1;
  // instance with sum/cout compare only
  logic        busy0, done0, pass0, mm0, ffv0, ffcin0;
  logic [31:0] vec0, err0, ffidx0;
  logic [2:0]  fl0;
  logic [7:0]  ffa0, ffb0;
  // instance with 2-bit counters, 3-vector runs
  logic        busy2, done2, pass2, mm2, ffv2, ffcin2;
  logic [1:0]  vec2, err2, ffidx2;
  logic [2:0]  fl2;
  logic [7:0]  ffa2, ffb2;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_check_monitor #(.n(8), .cmp_type(1'b1), .file_size(4), .CW(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .cin(cin), .a(a), .b(b),
    .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
    .prop_ref(prop_ref), .gen_ref(gen_ref), .prop_duv(prop_duv), .gen_duv(gen_duv),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch(mm1), .vec_count(vec1),
    .err_count(err1), .err_flags(fl1), .ff_valid(ffv1), .ff_idx(ffidx1),
    .ff_a(ffa1), .ff_b(ffb1), .ff_cin(ffcin1));

  adder_check_monitor #(.n(8), .cmp_type(1'b0), .file_size(4), .CW(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .cin(cin), .a(a), .b(b),
    .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
    .prop_ref(prop_ref), .gen_ref(gen_ref), .prop_duv(prop_duv), .gen_duv(gen_duv),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch(mm0), .vec_count(vec0),
    .err_count(err0), .err_flags(fl0), .ff_valid(ffv0), .ff_idx(ffidx0),
    .ff_a(ffa0), .ff_b(ffb0), .ff_cin(ffcin0));

  adder_check_monitor #(.n(8), .cmp_type(1'b1), .file_size(3), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .cin(cin), .a(a), .b(b),
    .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
    .prop_ref(prop_ref), .gen_ref(gen_ref), .prop_duv(prop_duv), .gen_duv(gen_duv),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch(mm2), .vec_count(vec2),
    .err_count(err2), .err_flags(fl2), .ff_valid(ffv2), .ff_idx(ffidx2),
    .ff_a(ffa2), .ff_b(ffb2), .ff_cin(ffcin2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one rising edge, return 1 time unit after it
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // vector a=0F b=01 cin=0, reference sum 10, cout 0, prop 1, gen 0;
  // the DUV side may be perturbed
  task automatic vec(input logic v, input logic [7:0] sd, input logic cd, input logic gd);
    valid = v; a = 8'h0F; b = 8'h01; cin = 1'b0;
    s_ref = 8'h10; s_duv = sd; cout_ref = 1'b0; cout_duv = cd;
    prop_ref = 1'b1; prop_duv = 1'b1; gen_ref = 1'b0; gen_duv = gd;
    tick;
    valid = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1; valid = 1'b0;
    tick;
    start = 1'b0;
  endtask

  initial begin
    logic [8:0] gaps;
    int exp_cnt;

    // reset state
    #12;
    chk("rst_busy", busy1, 0);   chk("rst_done", done1, 0);
    chk("rst_vec", vec1, 0);     chk("rst_err", err1, 0);
    chk("rst_pass", pass1, 0);   chk("rst_ffv", ffv1, 0);
    rst_n = 1'b1;

    // 1: clean run
    do_start;
    chk("t1_busy", busy1, 1);
    chk("t1_done", done1, 0);
    for (int i = 0; i < 4; i++) vec(1'b1, 8'h10, 1'b0, 1'b0);
    chk("t1_vec", vec1, 4);     chk("t1_err", err1, 0);
    chk("t1_done", done1, 1);   chk("t1_pass", pass1, 1);
    chk("t1_ffv", ffv1, 0);     chk("t1_busy", busy1, 0);

    // 2: sum mismatch at vector 2
    do_start;
    chk("t2_done", done1, 0);   chk("t2_pass", pass1, 0);
    vec(1'b1, 8'h10, 1'b0, 1'b0);
    vec(1'b1, 8'h10, 1'b0, 1'b0);
    chk("t2_mm_pre", mm1, 0);
    vec(1'b1, 8'h11, 1'b0, 1'b0);
    chk("t2_mm", mm1, 1);       chk("t2_err", err1, 1);
    chk("t2_flags", fl1, 3'b001);
    chk("t2_ffv", ffv1, 1);     chk("t2_ffidx", ffidx1, 2);
    chk("t2_ffa", ffa1, 8'h0F); chk("t2_ffb", ffb1, 8'h01);
    chk("t2_ffcin", ffcin1, 0);
    vec(1'b1, 8'h10, 1'b0, 1'b0);
    chk("t2_mm_post", mm1, 0);  chk("t2_done", done1, 1);
    chk("t2_pass", pass1, 0);

    // 3: gen mismatch at vector 0, cout mismatch at vector 3
    do_start;
    vec(1'b1, 8'h10, 1'b0, 1'b1);
    vec(1'b1, 8'h10, 1'b0, 1'b0);
    vec(1'b1, 8'h10, 1'b0, 1'b0);
    vec(1'b1, 8'h10, 1'b1, 1'b0);
    chk("t3_err_t1", err1, 2);       chk("t3_flags_t1", fl1, 3'b110);
    chk("t3_ffidx_t1", ffidx1, 0);   chk("t3_pass_t1", pass1, 0);
    chk("t3_err_t0", err0, 1);       chk("t3_flags_t0", fl0, 3'b010);
    chk("t3_ffidx_t0", ffidx0, 3);   chk("t3_done_t0", done0, 1);

    // 4: valid before start is ignored, then gaps within a run
    rst_n = 1'b0; #3; rst_n = 1'b1;
    vec(1'b1, 8'h11, 1'b1, 1'b0);
    vec(1'b1, 8'h11, 1'b1, 1'b0);
    chk("t4_pre_vec", vec1, 0);  chk("t4_pre_err", err1, 0);
    chk("t4_pre_mm", mm1, 0);    chk("t4_pre_busy", busy1, 0);
    do_start;
    gaps = 9'b100101001;  // bit i = valid in cycle i
    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      vec(gaps[i], 8'h10, 1'b0, 1'b0);
      if (gaps[i]) exp_cnt++;
      chk("t4_vec", vec1, exp_cnt);
      chk("t4_done", done1, (i == 8) ? 1 : 0);
    end
    chk("t4_pass", pass1, 1);

    // 5: saturating-width counters, every vector fails
    do_start;
    for (int i = 0; i < 3; i++) vec(1'b1, 8'h11, 1'b0, 1'b0);
    chk("t5_err", err2, 3);      chk("t5_vec", vec2, 3);
    chk("t5_done", done2, 1);    chk("t5_pass", pass2, 0);
    chk("t5_ffidx", ffidx2, 0);
    do_start;  // restart from DONE; dut1 is mid-run so it ignores this
    chk("t5_busy", busy2, 1);    chk("t5_done2", done2, 0);
    chk("t5_clr_err", err2, 0);  chk("t5_clr_vec", vec2, 0);
    chk("t5_clr_fl", fl2, 0);    chk("t5_clr_ffv", ffv2, 0);
    chk("t5_ign_vec", vec1, 3);  chk("t5_ign_busy", busy1, 1);
    vec(1'b1, 8'h11, 1'b0, 1'b0);
    chk("t5_d1_done", done1, 1); chk("t5_d1_err", err1, 4);

    // 6: asynchronous reset mid-run, then a full run
    do_start;
    vec(1'b1, 8'h11, 1'b0, 1'b0);
    vec(1'b1, 8'h10, 1'b0, 1'b0);
    chk("t6_mid_vec", vec1, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy1, 0); chk("t6_rst_vec", vec1, 0);
    chk("t6_rst_err", err1, 0);   chk("t6_rst_ffv", ffv1, 0);
    chk("t6_rst_ffa", ffa1, 0);   chk("t6_rst_fl", fl1, 0);
    #1 rst_n = 1'b1;
    do_start;
    for (int i = 0; i < 3; i++) vec(1'b1, 8'h10, 1'b0, 1'b0);
    start = 1'b1;  // coincides with last vector: run ends, start ignored
    vec(1'b1, 8'h10, 1'b0, 1'b0);
    start = 1'b0;
    chk("t6_vec", vec1, 4);      chk("t6_done", done1, 1);
    chk("t6_pass", pass1, 1);    chk("t6_busy", busy1, 0);
    tick;
    chk("t6_hold_done", done1, 1);
    chk("t6_hold_vec", vec1, 4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/adder_check_monitor.md
# adder_check_monitor

Synthesizable result checker that sits directly downstream of the adder under test and the reference adder in the adder verification bench. Each cycle it samples the operand vector plus both result sets, flags mismatches, counts checked and failing vectors, and latches the first failing vector. It declares a pass/fail verdict after a run of `file_size` vectors.

## Interface
Parameters:
- `n`, 32: operand and sum width.
- `type`, 1: compare mode. 0 = sum/cout only (csa, cra, a1csa). 1 = also compare prop/gen (cla, a1csah).
- `file_size`, 30000: vectors per run. Must be ≥1 and < 2^CW.
- `CW`, 32: counter width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a run.
- `valid` in 1: the vector on the inputs is valid this cycle.
- `cin` in 1: carry-in of the vector.
- `a` in n: operand A.
- `b` in n: operand B.
- `s_ref` in n: reference sum.
- `s_duv` in n: DUV sum.
- `cout_ref` in 1: reference carry-out.
- `cout_duv` in 1: DUV carry-out.
- `prop_ref`, `gen_ref` in 1 each: reference group propagate/generate.
- `prop_duv`, `gen_duv` in 1 each: DUV group propagate/generate.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until the next `start`.
- `pass` out 1: high only while `done` is high and `err_count == 0`.
- `mismatch` out 1: registered per-vector fail flag.
- `vec_count` out CW: vectors checked in the current run.
- `err_count` out CW: failing vectors; saturates at all-ones.
- `err_flags` out 3: sticky failure classes {pg, cout, sum}.
- `ff_valid` out 1: the first-fail capture registers hold data.
- `ff_idx` out CW: `vec_count` value (0-based) of the first failing vector.
- `ff_a`, `ff_b` out n each: operands of the first failing vector.
- `ff_cin` out 1: carry-in of the first failing vector.

## Operation
- FSM states: IDLE, RUN, DONE. The state is encoded in `busy` (RUN) and `done` (DONE).
- IDLE + `start`: go to RUN. On the same edge, clear `vec_count`, `err_count`, `err_flags`, `ff_*`, `mismatch` and `pass`.
- DONE + `start`: same as IDLE + `start`; `done` drops.
- RUN + `start`: ignored. A run cannot be restarted mid-run except by reset.
- In RUN, with `valid` high at an edge:
  - Compute `m_sum = (s_ref != s_duv)`.
  - Compute `m_cout = (cout_ref != cout_duv)`.
  - Compute `m_pg = (type==1) & ((prop_ref != prop_duv) | (gen_ref != gen_duv))`.
  - Set `mismatch <= m_sum | m_cout | m_pg`.
  - Increment `vec_count`.
  - If the vector mismatched, increment `err_count`, saturating at 2^CW-1. OR `{m_pg, m_cout, m_sum}` into `err_flags`.
  - If the vector mismatched and `ff_valid` is 0, capture `ff_idx <= vec_count` (pre-increment value), `ff_a`, `ff_b`, `ff_cin`, and set `ff_valid <= 1`. Later mismatches do not overwrite the capture.
- In RUN, with `valid` low at an edge: `mismatch <= 0`; all counters hold.
- Run completion: the edge that samples the `file_size`-th valid vector moves the FSM to DONE. On that edge, `pass <= (err_count_next == 0)`.
- `valid` outside RUN: ignored. Counters and flags hold; `mismatch <= 0`.
- `type == 0`: prop/gen inputs are ignored and `err_flags[2]` stays 0.

## Timing
- Reset (async assert, any state): FSM goes to IDLE. Every output becomes 0: `busy`, `done`, `pass`, `mismatch`, `vec_count`, `err_count`, `err_flags`, `ff_*`.
- Reset release: synchronous to `clk`, no extra latency. The first edge after deassertion may accept `start`.
- `busy` rises on the edge that samples `start`. The first vector is checked on the following edge.
- Compare latency is 1 cycle. `mismatch`, `vec_count`, `err_count`, `err_flags` and `ff_*` reflect the vector sampled at the previous edge.
- `done` and `pass` rise on the same edge as the final `vec_count` update. `busy` falls on that edge.
- `start` and the last valid vector on the same edge: the vector is checked first, the run completes, and `start` is ignored (the FSM was in RUN). A new `start` is needed in DONE.
- Reset mid-run: the run is aborted and all results are lost.

## Test plan
- `n=8`, `type=1`, `file_size=4`. `start`, then 4 vectors all matching (a=8'h0F, b=8'h01, s both 8'h10) → `vec_count=4`, `err_count=0`, `done=1`, `pass=1`, `ff_valid=0`, `busy=0` on the 5th edge after `start`.
- Same config; vector index 2 has `s_duv=8'h11` vs `s_ref=8'h10`, a=8'h0F, b=8'h01, cin=0 → `mismatch=1` for one cycle, `err_count=1`, `err_flags=3'b001`, `ff_idx=2`, `ff_a=8'h0F`, `ff_b=8'h01`, `pass=0`.
- Vector 0 has a `gen` mismatch and vector 3 has a `cout` mismatch. With `type=1` → `err_count=2`, `err_flags=3'b110`, `ff_idx=0`. With `type=0`, same stimulus → `err_count=1`, `err_flags=3'b010`, `ff_idx=3`.
- `valid` gaps: 4 valid vectors spread over 9 cycles → `vec_count` holds during gaps, and `done` rises on the edge of the 4th valid vector. `valid` pulses before `start` leave `vec_count=0`.
- `CW=2`, `file_size=3`, all 3 vectors mismatching → `err_count=3` (no wrap). Then `start` in DONE → all results cleared, `busy=1`, `done=0`.
- Assert `rst_n=0` asynchronously after 2 of 4 vectors, mid-cycle → all outputs 0 immediately. After release, a new `start` runs a full 4-vector pass with `vec_count=4`.
